hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage RV32I pipeline, placed beside the decode/execute stages. It generates:
- EX operand forwarding selects.
- Load-use stalls.
- Taken-branch/jump flushes.
- A whole-pipeline freeze while data memory is not ready, with a watchdog timeout.

It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/fwd_sel.sv | 31 +++
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
//    Shared types and encodings for the RV32I pipeline hazard controller.
//    state_t  : memory-wait FSM states (RUN, MEM_WAIT, ERROR)
//    FWD_*    : EX operand forwarding select encodings
//    RES_LOAD : ResultSrc encoding that marks a load instruction
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel
//    Forwarding select for one EX operand. The M stage has priority over W
//    because it holds the younger result. Register x0 is never forwarded.
//    Ports:
//       Rs        in  5  execute-stage source register
//       RdM       in  5  memory-stage destination
//       RegWriteM in  1  M stage writes the register file
//       RdW       in  5  writeback-stage destination
//       RegWriteW in  1  W stage writes the register file
//       Fwd       out 2  operand select (FWD_RF / FWD_WB / FWD_MEM)
module fwd_sel
   import hazard_pkg::*;
(
   input  logic [4:0] Rs,
   input  logic [4:0] RdM,
   input  logic       RegWriteM,
   input  logic [4:0] RdW,
   input  logic       RegWriteW,
   output logic [1:0] Fwd
);

   always_comb begin
      Fwd = FWD_RF;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs)) begin
         Fwd = FWD_MEM;
      end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs)) begin
         Fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//    Central hazard controller for the 5-stage RV32I pipeline.
//    Produces EX forwarding selects, load-use stalls, taken-branch flushes
//    and a whole-pipeline freeze while data memory is busy, with a watchdog
//    that latches a sticky error. Saturating stall/flush event counters are
//    kept for performance debug.
//    Ports:
//       clk, reset                      clock / synchronous active-high reset
//       Rs1D, Rs2D                      decode-stage sources
//       Rs1E, Rs2E, RdE, LoadE, PCSrcE  execute-stage info
//       RdM, RegWriteM, MemReqM, MemReadyM  memory-stage info
//       RdW, RegWriteW                  writeback-stage info
//       StallF..StallW, FlushD, FlushE  pipeline register controls
//       ForwardAE, ForwardBE            EX operand selects
//       MemErr                          sticky memory timeout
//       StallCnt, FlushCnt              saturating event counters
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic             LoadE,
   input  logic             PCSrcE,
   input  logic [4:0]       RdM,
   input  logic             RegWriteM,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteW,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             StallW,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   // Wait counter only ever holds 0..MEM_TIMEOUT-1.
   localparam int unsigned     WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              freeze;
   logic              lw_stall;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;

   fwd_sel u_fwd_a (
      .Rs        (Rs1E),
      .RdM       (RdM),
      .RegWriteM (RegWriteM),
      .RdW       (RdW),
      .RegWriteW (RegWriteW),
      .Fwd       (fwd_a)
   );

   fwd_sel u_fwd_b (
      .Rs        (Rs2E),
      .RdM       (RdM),
      .RegWriteM (RegWriteM),
      .RdW       (RdW),
      .RegWriteW (RegWriteW),
      .Fwd       (fwd_b)
   );

   always_comb begin
      lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   end

   // Freeze is raised combinationally in the very cycle the miss is seen,
   // and drops in the cycle MemReadyM arrives.
   always_comb begin
      freeze = ((state == RUN) && MemReqM && !MemReadyM) ||
               ((state == MEM_WAIT) && !MemReadyM) ||
               (state == ERROR);
   end

   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      StallW    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (reset) begin
         FlushD    = 1'b1;
         FlushE    = 1'b1;
         ForwardAE = FWD_RF;
         ForwardBE = FWD_RF;
      end else if (freeze) begin
         // A branch or load-use sitting in E is held and handled after unfreeze.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         StallW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lw_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
         MemErr   <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (MemReqM && !MemReadyM) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (MemReadyM) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state  <= ERROR;
                  MemErr <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ERROR: begin
               MemErr <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if ((freeze || lw_stall) && (StallCnt != '1)) begin
            StallCnt <= StallCnt + CNT_W'(1);
         end
         if (PCSrcE && !freeze && (FlushCnt != '1)) begin
            FlushCnt <= FlushCnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//    Directed self-checking bench for hazard_ctrl. A second instance with a
//    short timeout and 4-bit counters covers the watchdog boundary and
//    counter saturation.
module tb_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       LoadE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;

   logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        MemErr;
   logic [31:0] StallCnt, FlushCnt;

   logic        s_StallF, s_StallD, s_StallE, s_StallM, s_StallW, s_FlushD, s_FlushE;
   logic [1:0]  s_ForwardAE, s_ForwardBE;
   logic        s_MemErr;
   logic [3:0]  s_StallCnt, s_FlushCnt;

   logic [6:0]  ctrl;
   int          checks;
   int          errors;

   // {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE}
   assign ctrl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};

   localparam logic [6:0] C_IDLE   = 7'b0000000;
   localparam logic [6:0] C_RESET  = 7'b0000011;
   localparam logic [6:0] C_FREEZE = 7'b1111100;
   localparam logic [6:0] C_BRANCH = 7'b0000011;
   localparam logic [6:0] C_LWSTL  = 7'b1100001;

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .LoadE(LoadE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM), .RdW(RdW), .RegWriteW(RegWriteW),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .LoadE(LoadE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM), .RdW(RdW), .RegWriteW(RegWriteW),
      .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
      .StallW(s_StallW), .FlushD(s_FlushD), .FlushE(s_FlushE),
      .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .MemErr(s_MemErr),
      .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
      LoadE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; MemReqM = 1'b0;
      MemReadyM = 1'b0; RegWriteW = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      // Hazards present during reset must not leak through.
      Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
      LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
      tick();
      tick();
      checks++;
      if (ctrl !== C_RESET) begin
         errors++; $display("FAIL reset_ctrl got %b exp %b", ctrl, C_RESET);
      end
      checks++;
      if (ForwardAE !== 2'b00) begin
         errors++; $display("FAIL reset_fwd got %b exp 00", ForwardAE);
      end
      checks++;
      if (MemErr !== 1'b0 || StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_regs got err=%b sc=%0d fc=%0d exp 0 0 0", MemErr, StallCnt, FlushCnt);
      end
      clear_inputs();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_forwarding();
      clear_inputs();
      Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
      #1;
      checks++;
      if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
         errors++; $display("FAIL fwd_mem_prio got %b/%b exp 10/10", ForwardAE, ForwardBE);
      end
      RegWriteM = 1'b0;
      #1;
      checks++;
      if (ForwardAE !== 2'b01) begin
         errors++; $display("FAIL fwd_wb got %b exp 01", ForwardAE);
      end
      Rs2E = 5'd3;
      #1;
      checks++;
      if (ForwardBE !== 2'b00) begin
         errors++; $display("FAIL fwd_b_nomatch got %b exp 00", ForwardBE);
      end
      Rs1E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd0;
      #1;
      checks++;
      if (ForwardAE !== 2'b00) begin
         errors++; $display("FAIL fwd_x0 got %b exp 00", ForwardAE);
      end
      Rs1E = 5'd9; Rs2E = 5'd9; RdM = 5'd4; RdW = 5'd9; RegWriteW = 1'b0;
      #1;
      checks++;
      if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
         errors++; $display("FAIL fwd_nowrite got %b/%b exp 00/00", ForwardAE, ForwardBE);
      end
      RegWriteW = 1'b1; RdM = 5'd9; RegWriteM = 1'b0;
      #1;
      checks++;
      if (ForwardBE !== 2'b01 || ctrl !== C_IDLE) begin
         errors++; $display("FAIL fwd_b_wb got %b ctrl %b exp 01 ctrl %b", ForwardBE, ctrl, C_IDLE);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      #1;
      checks++;
      if (ctrl !== C_LWSTL) begin
         errors++; $display("FAIL lw_rs2 got %b exp %b", ctrl, C_LWSTL);
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if (ctrl !== C_IDLE || StallCnt !== 32'd1) begin
         errors++; $display("FAIL lw_after got ctrl %b sc %0d exp %b 1", ctrl, StallCnt, C_IDLE);
      end
      LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
      #1;
      checks++;
      if (ctrl !== C_IDLE) begin
         errors++; $display("FAIL lw_x0 got %b exp %b", ctrl, C_IDLE);
      end
      tick();
      RdE = 5'd9; Rs1D = 5'd9; Rs2D = 5'd2;
      #1;
      checks++;
      if (ctrl !== C_LWSTL) begin
         errors++; $display("FAIL lw_rs1 got %b exp %b", ctrl, C_LWSTL);
      end
      tick();
      clear_inputs();
      checks++;
      if (StallCnt !== 32'd2) begin
         errors++; $display("FAIL lw_cnt got %0d exp 2", StallCnt);
      end
   endtask

   task automatic test_branch();
      do_reset();
      PCSrcE = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_BRANCH) begin
         errors++; $display("FAIL br_flush got %b exp %b", ctrl, C_BRANCH);
      end
      tick();
      PCSrcE = 1'b0;
      #1;
      checks++;
      if (FlushCnt !== 32'd1 || ctrl !== C_IDLE) begin
         errors++; $display("FAIL br_cnt got fc %0d ctrl %b exp 1 %b", FlushCnt, ctrl, C_IDLE);
      end
      PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
      #1;
      checks++;
      if (ctrl !== C_BRANCH) begin
         errors++; $display("FAIL br_over_lw got %b exp %b", ctrl, C_BRANCH);
      end
      tick();
      clear_inputs();
      checks++;
      if (FlushCnt !== 32'd2 || StallCnt !== 32'd1) begin
         errors++; $display("FAIL br_lw_cnt got fc %0d sc %0d exp 2 1", FlushCnt, StallCnt);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ctrl !== C_FREEZE) begin
            errors++; $display("FAIL mw_freeze%0d got %b exp %b", i, ctrl, C_FREEZE);
         end
         tick();
      end
      MemReadyM = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_BRANCH) begin
         errors++; $display("FAIL mw_ready got %b exp %b", ctrl, C_BRANCH);
      end
      tick();
      PCSrcE = 1'b0; MemReqM = 1'b1; MemReadyM = 1'b1;
      #1;
      checks++;
      if (StallCnt !== 32'd3 || FlushCnt !== 32'd1 || ctrl !== C_IDLE) begin
         errors++;
         $display("FAIL mw_cnt got sc %0d fc %0d ctrl %b exp 3 1 %b", StallCnt, FlushCnt, ctrl, C_IDLE);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         #1;
         if (k == 16) begin
            checks++;
            if (ctrl !== C_FREEZE || MemErr !== 1'b0) begin
               errors++; $display("FAIL to_last got ctrl %b err %b exp %b 0", ctrl, MemErr, C_FREEZE);
            end
         end
         tick();
         // Short-timeout instance errors after its 4th frozen cycle.
         if (k == 3 || k == 4) begin
            checks++;
            if (s_MemErr !== (k == 4)) begin
               errors++; $display("FAIL to_short_k%0d got %b exp %b", k, s_MemErr, (k == 4));
            end
         end
      end
      checks++;
      if (MemErr !== 1'b1 || StallCnt !== 32'd16) begin
         errors++; $display("FAIL to_err got err %b sc %0d exp 1 16", MemErr, StallCnt);
      end
      MemReqM = 1'b0; MemReadyM = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_FREEZE) begin
         errors++; $display("FAIL to_hold got %b exp %b", ctrl, C_FREEZE);
      end
      tick();
      tick();
      checks++;
      if (ctrl !== C_FREEZE || MemErr !== 1'b1 || StallCnt !== 32'd18) begin
         errors++; $display("FAIL to_sticky got ctrl %b err %b sc %0d exp %b 1 18", ctrl, MemErr, StallCnt, C_FREEZE);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_RESET) begin
         errors++; $display("FAIL to_rst_ctrl got %b exp %b", ctrl, C_RESET);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (MemErr !== 1'b0 || StallCnt !== 32'd0 || FlushCnt !== 32'd0 || ctrl !== C_IDLE) begin
         errors++;
         $display("FAIL to_cleared got err %b sc %0d fc %0d ctrl %b exp 0 0 0 %b", MemErr, StallCnt, FlushCnt, ctrl, C_IDLE);
      end
      MemReqM = 1'b1; MemReadyM = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_IDLE || s_StallE !== 1'b0) begin
         errors++; $display("FAIL to_run got %b/%b exp %b/0", ctrl, s_StallE, C_IDLE);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) begin
            checks++;
            if (s_StallCnt !== 4'd14) begin
               errors++; $display("FAIL sat_14 got %0d exp 14", s_StallCnt);
            end
         end
      end
      checks++;
      if (s_StallCnt !== 4'hF || StallCnt !== 32'd20) begin
         errors++; $display("FAIL sat_hold got %0d/%0d exp 15/20", s_StallCnt, StallCnt);
      end
      clear_inputs();
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_inputs();
      reset = 1'b1;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
